// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter guarding one shared register: NREQ requesters compete for a
// single write slot, with one write completing at most every three cycles.
module shared_reg_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*WIDTH-1:0]     wdata,
    input  logic                      clr,
    output logic [NREQ-1:0]           gnt,
    output logic [NREQ-1:0]           ack,
    output logic [WIDTH-1:0]          q,
    output logic                      busy,
    output logic [$clog2(NREQ)-1:0]   last_id
);

    localparam int IW = $clog2(NREQ);
    localparam logic [IW:0] NREQ_W = (IW + 1)'(NREQ);

    typedef enum logic [1:0] {IDLE, GRANT, ACK} state_t;

    state_t            state, state_nxt;
    logic [IW-1:0]     ptr, winner, pick, ptr_after;
    logic [IW-1:0]     ptr_d, winner_d, last_id_d;
    logic [IW:0]       idx;
    logic              found, win_req;
    logic [WIDTH-1:0]  wsel, q_d;
    logic [NREQ-1:0]   gnt_d, ack_d;

    // Round-robin search starting at ptr, wrapping modulo NREQ.
    always_comb begin
        pick  = ptr;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            // NOTE: blocking assignments here, so each iteration sees the idx it just computed.
            idx = {1'b0, ptr} + (IW + 1)'(k);
            if (idx >= NREQ_W) idx = idx - NREQ_W;
            if (!found && req[idx[IW-1:0]]) begin
                pick  = idx[IW-1:0];
                found = 1'b1;
            end
        end
    end

    always_comb begin
        wsel = '0;
        for (int i = 0; i < NREQ; i++)
            if (IW'(i) == winner) wsel = wdata[i*WIDTH +: WIDTH];
    end

    assign win_req   = req[winner];
    assign ptr_after = (winner == IW'(NREQ - 1)) ? '0 : winner + IW'(1);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        // NOTE: non-blocking for every register, so all of them update from pre-edge values.
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = IDLE;
        unique case (state)
            IDLE:    state_nxt = found ? GRANT : IDLE;
            GRANT:   state_nxt = win_req ? ACK : IDLE;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath.
    always_comb begin
        // NOTE: every signal gets a default first so no latch is inferred on untaken paths.
        gnt_d     = '0;
        ack_d     = '0;
        q_d       = q;
        ptr_d     = ptr;
        winner_d  = winner;
        last_id_d = last_id;
        unique case (state)
            IDLE: begin
                if (found) begin
                    winner_d = pick;
                    gnt_d    = NREQ'(1) << pick;
                end
            end
            GRANT: begin
                if (win_req) begin
                    q_d       = wsel;
                    ack_d     = NREQ'(1) << winner;
                    last_id_d = winner;
                    ptr_d     = ptr_after;
                end
            end
            default: ;
        endcase
        // Clear wins over a simultaneous write; the handshake still completes.
        if (clr) q_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt     <= '0;
            ack     <= '0;
            q       <= '0;
            ptr     <= '0;
            winner  <= '0;
            last_id <= '0;
        end else begin
            gnt     <= gnt_d;
            ack     <= ack_d;
            q       <= q_d;
            ptr     <= ptr_d;
            winner  <= winner_d;
            last_id <= last_id_d;
        end
    end

endmodule

// File: doc/shared_reg_arbiter.md
SHARED_REG_ARBITER -- requirements
Module: shared_reg_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the register (2..8).
REQ-002 Parameter WIDTH, default 8, width of the shared register.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 req  input  NREQ  per-requester write request, bit i = requester i.
REQ-006 wdata  input  NREQ*WIDTH  flat write data, requester i at bits [i*WIDTH +: WIDTH].
REQ-007 clr  input  1  synchronous clear of the shared register.
REQ-008 gnt  output  NREQ  registered one-hot grant.
REQ-009 ack  output  NREQ  registered one-hot write-complete pulse.
REQ-010 q  output  WIDTH  shared register contents.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 last_id  output  ceil(log2(NREQ))  index of the requester whose write last completed.

Function
REQ-013 FSM SHALL have three states (IDLE, GRANT, ACK) and be held in registers.
REQ-014 IDLE: if req is nonzero, select winner round-robin starting at pointer ptr, searching ptr, ptr+1, ... modulo NREQ; register gnt = one-hot(winner); go to GRANT; else stay IDLE with gnt = 0.
REQ-015 GRANT (gnt high exactly one cycle): if req[winner] is still 1, then at the closing edge q <= wdata[winner], ack <= one-hot(winner), last_id <= winner, ptr <= (winner+1) mod NREQ, gnt <= 0, go to ACK.
REQ-016 GRANT with req[winner] = 0 (withdrawn): abort; q, ptr, last_id unchanged; no ack; gnt <= 0; return to IDLE.
REQ-017 ACK: ack high exactly one cycle; no arbitration in this cycle; go to IDLE; ack <= 0.
REQ-018 Latency: req sampled at edge E0 -> gnt high after E0 -> q updated and ack high after E1 -> IDLE after E2; max throughput one write per 3 cycles.
REQ-019 Requesters SHALL hold req and wdata stable from assertion until ack is seen; a requester may keep req high after ack to request again.
REQ-020 Pointer wrap: winner = NREQ-1 sets ptr to 0.
REQ-021 A requester just served has lowest priority next arbitration; with all req high, grants rotate 0,1,...,NREQ-1,0.
REQ-022 clr = 1 sets q <= 0 at the next edge in any state; takes precedence over a simultaneous GRANT write (write data discarded, but ack, last_id, ptr still update as in REQ-015).
REQ-023 gnt and ack SHALL never have more than one bit set and SHALL never be high in the same cycle.
REQ-024 busy SHALL be combinational from state only.

Reset
REQ-025 rst_n = 0 SHALL immediately force state = IDLE, q = 0, gnt = 0, ack = 0, busy = 0, ptr = 0, last_id = 0, independent of clk.
REQ-026 Reset asserted mid-transaction (GRANT or ACK) abandons it: no write, no ack after release.
REQ-027 After rst_n deassertion, the first arbitration starts from requester 0.

Verification
REQ-028 NREQ=4, WIDTH=8; after reset req=4'b0100, wdata[2]=8'hA5 -> gnt=4'b0100 for 1 cycle, next cycle q=8'hA5, ack=4'b0100, last_id=2, then busy=0.
REQ-029 req=4'b1111 held continuously with wdata[i]=8'h10+i -> grant order 0,1,2,3,0; q sequence 8'h10,8'h11,8'h12,8'h13,8'h10, one ack every 3 cycles.
REQ-030 req=4'b1000 then drop req[3] during GRANT -> no ack, q unchanged, ptr unchanged; next req=4'b1001 grants requester 0.
REQ-031 clr=1 in the GRANT cycle of a write of 8'hFF by requester 1 -> q=8'h00, ack=4'b0010, last_id=1.
REQ-032 rst_n pulsed low between clock edges while in GRANT -> outputs zero immediately, no ack afterward, next arbitration with req=4'b1010 grants requester 1.
